// File: rtl/link_pkg.sv
// Shared definitions for the GB link peer: state encoding, idle byte and
// default timing constants also used by the serial port block.
package link_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SLV_SHIFT = 3'd1,
    MST_LOW   = 3'd2,
    MST_HIGH  = 3'd3,
    COMMIT    = 3'd4
  } link_state_e;

  localparam logic [7:0] IDLE_BYTE      = 8'hFF;
  localparam int         HALF_DIV_DEF   = 256;
  localparam int         TIMEOUT_DEF    = 4096;
  localparam int         FIFO_DEPTH_DEF = 4;

  function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
    return {v[6:0], b};
  endfunction

endpackage

// File: rtl/link_if.sv
// Host-side byte streams of the link peer: received bytes out, bytes to send in.
interface link_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/link_fifo.sv
// Synchronous byte FIFO with registered occupancy; DEPTH must be a power of two
// so the pointers wrap naturally.
module link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s, do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && !full;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end
endmodule

// File: rtl/link_peer.sv
// GB serial link peer: exchanges bytes with a GB serial port as clock slave or
// clock master, buffering host traffic in rx/tx FIFOs.
module link_peer #(
  parameter int HALF_DIV   = link_pkg::HALF_DIV_DEF,
  parameter int TIMEOUT    = link_pkg::TIMEOUT_DEF,
  parameter int FIFO_DEPTH = link_pkg::FIFO_DEPTH_DEF
) (
  input  logic   clk_sys,
  input  logic   rst,
  input  logic   ce,
  input  logic   gb_clk_out,
  input  logic   gb_data_out,
  input  logic   gb_int_clock,
  output logic   gb_clk_in,
  output logic   gb_data_in,
  link_if.slave  host,
  output logic   busy,
  output logic   overrun,
  output logic   timeout_err,
  input  logic   ovr_clr
);
  import link_pkg::*;

  localparam int            DW       = $clog2(HALF_DIV) + 1;
  localparam int            TW       = $clog2(TIMEOUT) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  link_state_e   state_r, state_nx;
  logic [7:0]    tx_shift_r, tx_shift_nx, rx_shift_r, rx_shift_nx;
  logic [2:0]    bit_cnt_r, bit_cnt_nx;
  logic [DW-1:0] div_cnt_r, div_cnt_nx;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_nx;
  logic          clk_prev_r, clk_in_r, clk_in_nx, data_in_r, data_in_nx;
  logic          overrun_r, timeout_r;
  logic          tx_pop_s, rx_push_s, ovr_set_s, tmo_set_s, rise_s, fall_s;
  logic [7:0]    tx_head_s, load_byte_s;
  logic          tx_empty_s, tx_full_s, rx_full_s, rx_empty_s;

  assign rise_s        = !clk_prev_r && gb_clk_out;
  assign fall_s        = clk_prev_r && !gb_clk_out;
  assign gb_clk_in     = clk_in_r;
  assign gb_data_in    = data_in_r;
  assign busy          = (state_r != IDLE);
  assign overrun       = overrun_r;
  assign timeout_err   = timeout_r;
  assign host.tx_ready = !tx_full_s;
  assign host.rx_valid = !rx_empty_s;

  link_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_sys), .rst(rst), .push(host.tx_valid), .push_data(host.tx_data),
    .pop(ce && tx_pop_s), .pop_data(tx_head_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  link_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_sys), .rst(rst), .push(ce && rx_push_s), .push_data(rx_shift_r),
    .pop(host.rx_ready), .pop_data(host.rx_data), .full(rx_full_s), .empty(rx_empty_s)
  );

  // Next-state and datapath decode for the exchange FSM.
  always_comb begin
    state_nx    = state_r;
    tx_shift_nx = tx_shift_r;
    rx_shift_nx = rx_shift_r;
    bit_cnt_nx  = bit_cnt_r;
    div_cnt_nx  = div_cnt_r;
    tmo_cnt_nx  = tmo_cnt_r;
    clk_in_nx   = clk_in_r;
    data_in_nx  = data_in_r;
    tx_pop_s    = 1'b0;
    rx_push_s   = 1'b0;
    ovr_set_s   = 1'b0;
    tmo_set_s   = 1'b0;
    load_byte_s = tx_empty_s ? IDLE_BYTE : tx_head_s;
    case (state_r)
      IDLE: begin
        bit_cnt_nx = 3'd0;
        div_cnt_nx = {DW{1'b0}};
        tmo_cnt_nx = {TW{1'b0}};
        clk_in_nx  = 1'b0;
        // The mode is decided here only; the state itself remembers it until IDLE.
        if (gb_int_clock) begin
          if (fall_s) begin
            state_nx    = SLV_SHIFT;
            tx_shift_nx = load_byte_s;
            tx_pop_s    = !tx_empty_s;
            data_in_nx  = load_byte_s[7];
          end else begin
            state_nx = IDLE;
          end
        end else if (!tx_empty_s) begin
          state_nx    = MST_LOW;
          tx_shift_nx = tx_head_s;
          tx_pop_s    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      SLV_SHIFT: begin
        if (rise_s) begin
          rx_shift_nx = shift_in(rx_shift_r, gb_data_out);
          tx_shift_nx = {tx_shift_r[6:0], 1'b0};
          bit_cnt_nx  = bit_cnt_r + 3'd1;
          tmo_cnt_nx  = {TW{1'b0}};
          state_nx    = (bit_cnt_r == 3'd7) ? COMMIT : SLV_SHIFT;
        end else if (fall_s) begin
          data_in_nx = tx_shift_r[7];
          tmo_cnt_nx = {TW{1'b0}};
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_set_s  = 1'b1;
          state_nx   = IDLE;
          data_in_nx = 1'b1;
          bit_cnt_nx = 3'd0;
          tmo_cnt_nx = {TW{1'b0}};
        end else begin
          tmo_cnt_nx = tmo_cnt_r + TW'(1);
        end
      end
      MST_LOW: begin
        if (div_cnt_r == DIV_LAST) begin
          clk_in_nx  = 1'b1;
          data_in_nx = tx_shift_r[7];
          div_cnt_nx = {DW{1'b0}};
          state_nx   = MST_HIGH;
        end else begin
          div_cnt_nx = div_cnt_r + DW'(1);
        end
      end
      MST_HIGH: begin
        if (div_cnt_r == DIV_LAST) begin
          clk_in_nx   = 1'b0;
          rx_shift_nx = shift_in(rx_shift_r, gb_data_out);
          tx_shift_nx = {tx_shift_r[6:0], 1'b0};
          bit_cnt_nx  = bit_cnt_r + 3'd1;
          div_cnt_nx  = {DW{1'b0}};
          state_nx    = (bit_cnt_r == 3'd7) ? COMMIT : MST_LOW;
        end else begin
          div_cnt_nx = div_cnt_r + DW'(1);
        end
      end
      COMMIT: begin
        if (rx_full_s) begin
          ovr_set_s = 1'b1;
        end else begin
          rx_push_s = 1'b1;
        end
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM/datapath registers advance on ce; sticky flags may be cleared any cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r    <= IDLE;
      tx_shift_r <= IDLE_BYTE;
      rx_shift_r <= 8'h00;
      bit_cnt_r  <= 3'd0;
      div_cnt_r  <= {DW{1'b0}};
      tmo_cnt_r  <= {TW{1'b0}};
      clk_prev_r <= gb_clk_out;
      clk_in_r   <= 1'b0;
      data_in_r  <= 1'b1;
      overrun_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      if (ce) begin
        state_r    <= state_nx;
        tx_shift_r <= tx_shift_nx;
        rx_shift_r <= rx_shift_nx;
        bit_cnt_r  <= bit_cnt_nx;
        div_cnt_r  <= div_cnt_nx;
        tmo_cnt_r  <= tmo_cnt_nx;
        clk_prev_r <= gb_clk_out;
        clk_in_r   <= clk_in_nx;
        data_in_r  <= data_in_nx;
      end
      if (ce && ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr) begin
        overrun_r <= 1'b0;
      end
      if (ce && tmo_set_s) begin
        timeout_r <= 1'b1;
      end else if (ovr_clr) begin
        timeout_r <= 1'b0;
      end
    end
  end
endmodule

// File: doc/link_peer.md
LINK_PEER -- requirements
Module: link_peer

Interface
REQ-001 SHALL have parameter HALF_DIV, default 256: ce ticks per half serial clock period when the peer is clock master.
REQ-002 SHALL have parameter TIMEOUT, default 4096: ce ticks without a GB clock edge mid-byte before the peer aborts.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries in each of the rx and tx byte FIFOs (power of two).
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ce  in  1  clock enable; all timing, edge detection and counters advance only when ce=1.
REQ-007 gb_clk_out  in  1  serial clock driven by the GB serial port.
REQ-008 gb_data_out  in  1  serial data driven by the GB serial port.
REQ-009 gb_int_clock  in  1  GB SC bit0; 1 means the GB is clock master.
REQ-010 gb_clk_in  out  1  serial clock to the GB, valid when the peer is clock master.
REQ-011 gb_data_in  out  1  serial data to the GB.
REQ-012 rx_data / rx_valid / rx_ready  out 8 / out 1 / in 1  received-byte stream to host; a byte transfers when rx_valid and rx_ready are both 1.
REQ-013 tx_data / tx_valid / tx_ready  in 8 / in 1 / out 1  bytes to send to host-side GB; a byte transfers when tx_valid and tx_ready are both 1.
REQ-014 busy  out  1  byte exchange in progress.
REQ-015 overrun / timeout_err  out 1 / out 1  sticky error flags; ovr_clr (in, 1) clears both.

Function
REQ-016 States: IDLE, SLV_SHIFT, MST_LOW, MST_HIGH, COMMIT.
REQ-017 Clock edge detect: register gb_clk_out on each ce tick; rise = prev 0 and now 1; fall = prev 1 and now 0.
REQ-018 IDLE: load tx_shift from the tx FIFO head (pop), or 8'hFF if the FIFO is empty, upon leaving IDLE.
REQ-019 IDLE with gb_int_clock=1: the first fall of gb_clk_out enters SLV_SHIFT and drives gb_data_in=tx_shift[7] on that same ce tick.
REQ-020 SLV_SHIFT: on each rise, rx_shift <= {rx_shift[6:0], gb_data_out}, tx_shift shifts left, bit_cnt increments; on each fall, gb_data_in <= tx_shift[7].
REQ-021 SLV_SHIFT: the eighth rise goes to COMMIT.
REQ-022 IDLE with gb_int_clock=0 and a nonempty tx FIFO enters MST_LOW with gb_clk_in=0.
REQ-023 MST_LOW: after HALF_DIV ticks, gb_clk_in goes to 1, gb_data_in <= tx_shift[7], and the state goes to MST_HIGH.
REQ-024 MST_HIGH: after HALF_DIV ticks, gb_clk_in goes to 0, rx_shift samples gb_data_out, and bit_cnt increments; after 8 bits go to COMMIT, otherwise go to MST_LOW.
REQ-025 gb_clk_in idles at 0.
REQ-026 Mode is latched when leaving IDLE; gb_int_clock changes mid-byte are ignored until the state returns to IDLE.
REQ-027 COMMIT, one tick: push rx_shift to the rx FIFO; if the rx FIFO is full, drop the byte and set overrun; then go to IDLE.
REQ-028 A byte pushed in COMMIT is visible on rx_valid on the next clk_sys cycle.
REQ-029 SLV_SHIFT with no gb_clk_out edge for TIMEOUT ticks: set timeout_err, discard the partial byte, return to IDLE, and drive gb_data_in to 1.
REQ-030 An ovr_clr in the same cycle as a new error: the set wins.
REQ-031 FIFOs: tx_ready = !tx_full and rx_valid = !rx_empty; simultaneous push and pop are legal at any fill level and keep the count unchanged when 0 < count < depth; pointers wrap modulo FIFO_DEPTH.
REQ-032 busy = (state != IDLE).
REQ-033 bit_cnt is 3 bits and wraps to 0 at COMMIT.

Reset
REQ-034 rst SHALL force state IDLE, gb_clk_in=0, gb_data_in=1, busy=0, overrun=0, timeout_err=0, rx_valid=0, tx_ready=1, both FIFOs empty, and bit_cnt and the timeout counter to 0.
REQ-035 rst mid-byte SHALL abandon the byte with no FIFO push or pop and no flag set.
REQ-036 rst SHALL take priority over ce.

Structure
REQ-037 link_pkg SHALL hold the state encoding, IDLE_BYTE=8'hFF, and the default HALF_DIV and TIMEOUT constants, shared with the serial port block.
REQ-038 One sub-module SHALL be used, link_fifo (parameterised width and depth, synchronous, full/empty outputs), instantiated twice (rx and tx).

Verification
REQ-039 Slave exchange: tx push 8'hA5; GB master clocks out 8'h3C (8 falls/rises) -> GB samples 8'hA5; rx_data=8'h3C, rx_valid=1 one cycle after COMMIT.
REQ-040 Empty tx FIFO, GB master sends 8'h12 -> GB receives 8'hFF; rx byte is 8'h12.
REQ-041 Master mode: gb_int_clock=0, tx push 8'h81, HALF_DIV=4 -> gb_clk_in shows 8 high pulses of 4 ticks each; busy falls after COMMIT; GB-driven 8'h7E appears on rx.
REQ-042 rx FIFO holding 4 bytes with rx_ready=0; fifth byte received -> byte dropped, overrun=1; ovr_clr pulse -> overrun=0.
REQ-043 GB stops after 3 bits with TIMEOUT=16 -> timeout_err=1 at tick 16, state IDLE, no rx push; next full byte is received correctly.
REQ-044 rst asserted at bit 5 of a master transfer -> gb_clk_in=0, busy=0, FIFOs empty next cycle.
